// File: rtl/sr_bank_pkg.sv
// Shared types and constants for the SR flag bank controller.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sr_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above ptr, wrapping around.
//   req     : request vector
//   ptr     : highest-priority requester this cycle
//   enable  : when low, no grant is issued
//   gnt     : one-hot grant
//   gnt_idx : encoded index of the granted requester (0 when no grant)
module sr_rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PTRW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    input  logic            enable,
    output logic [NREQ-1:0] gnt,
    output logic [PTRW-1:0] gnt_idx
);

    int unsigned     cand;
    logic [PTRW-1:0] cand_idx;
    logic            found;

    // Scan from ptr upward; the first hit wins.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = 32'(ptr) + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = PTRW'(cand);
            if (enable && !found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Shares a bank of NFLAG external SR flops between NREQ requesters.
// A round-robin arbiter grants one set/clear command per cycle, which becomes
// a registered one-cycle s/r pulse; a clear-all sweep walks every flag.
//   clk, rst   : clock, asynchronous active-low reset
//   req_valid  : per-requester command valid
//   req_op     : per-requester opcode (1 = set, 0 = clear)
//   req_idx    : packed per-requester flag index
//   req_ready  : one-hot grant (combinational)
//   clr_all    : pulse that starts the clear-all sweep
//   s_vec/r_vec: registered set/reset drives to the bank
//   flag_q     : shadow copy of the bank state
//   busy       : sweep in progress
//   sweep_done : one-cycle pulse at sweep completion
module sr_bank_ctrl
    import sr_bank_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    parameter  int unsigned NFLAG = 8,
    localparam int unsigned IDXW  = $clog2(NFLAG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 clr_all,
    output logic [NFLAG-1:0]     s_vec,
    output logic [NFLAG-1:0]     r_vec,
    output logic [NFLAG-1:0]     flag_q,
    output logic                 busy,
    output logic                 sweep_done
);

    localparam int unsigned PTRW = $clog2(NREQ);

    state_e           state_q, state_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  sweep_idx_q, sweep_idx_d;
    logic [NFLAG-1:0] s_vec_q, s_vec_d;
    logic [NFLAG-1:0] r_vec_q, r_vec_d;
    logic [NFLAG-1:0] flag_d;
    logic             busy_q, busy_d;
    logic             sweep_done_q, sweep_done_d;

    logic [NREQ-1:0]  gnt;
    logic [PTRW-1:0]  gnt_idx;
    logic             arb_en;
    logic             cmd_op;
    logic [IDXW-1:0]  cmd_idx;

    assign arb_en = (state_q == IDLE) && !clr_all;

    sr_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign cmd_op    = req_op[gnt_idx];
    assign cmd_idx   = IDXW'(req_idx >> (32'(gnt_idx) * IDXW));

    // The shadow follows what the bank captures from the registered drives.
    assign flag_d = (flag_q | s_vec_q) & ~r_vec_q;

    // Next-state and drive logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sweep_idx_d  = sweep_idx_q;
        s_vec_d      = '0;
        r_vec_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (clr_all) begin
                    state_d     = SWEEP;
                    sweep_idx_d = '0;
                end else if (|gnt) begin
                    ptr_d = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);
                    // Out-of-range indices are granted but produce no drive.
                    if (32'(cmd_idx) < NFLAG) begin
                        if (cmd_op == OP_SET) begin
                            s_vec_d = NFLAG'(1) << cmd_idx;
                        end else begin
                            r_vec_d = NFLAG'(1) << cmd_idx;
                        end
                    end
                end
            end
            SWEEP: begin
                r_vec_d = NFLAG'(1) << sweep_idx_q;
                if (sweep_idx_q == IDXW'(NFLAG - 1)) begin
                    state_d = DONE;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDXW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d       = (state_d == SWEEP);
        sweep_done_d = (state_d == DONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            sweep_idx_q  <= '0;
            s_vec_q      <= '0;
            r_vec_q      <= '0;
            flag_q       <= '0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sweep_idx_q  <= sweep_idx_d;
            s_vec_q      <= s_vec_d;
            r_vec_q      <= r_vec_d;
            flag_q       <= flag_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign s_vec      = s_vec_q;
    assign r_vec      = r_vec_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Bench for sr_bank_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model; a second NFLAG=6 instance covers
// out-of-range indices.
module tb_sr_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_op, req_ready;
    logic [11:0] req_idx;
    logic        clr_all;
    logic [7:0]  s_vec, r_vec, flag_q;
    logic        busy, sweep_done;

    logic [3:0]  req_valid6, req_op6, req_ready6;
    logic [11:0] req_idx6;
    logic [5:0]  s_vec6, r_vec6, flag_q6;
    logic        busy6, sweep_done6;
    logic        clr_all6;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt;

    // Model state
    int         m_mode;   // 0 idle, 1 sweeping, 2 done
    int         m_sidx;
    int         m_ptr;
    logic [7:0] m_flags, m_s, m_r;

    always #5 clk = ~clk;

    sr_bank_ctrl #(.NREQ(4), .NFLAG(8)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_idx(req_idx), .req_ready(req_ready), .clr_all(clr_all),
        .s_vec(s_vec), .r_vec(r_vec), .flag_q(flag_q), .busy(busy),
        .sweep_done(sweep_done)
    );

    sr_bank_ctrl #(.NREQ(4), .NFLAG(6)) u_dut6 (
        .clk(clk), .rst(rst), .req_valid(req_valid6), .req_op(req_op6),
        .req_idx(req_idx6), .req_ready(req_ready6), .clr_all(clr_all6),
        .s_vec(s_vec6), .r_vec(r_vec6), .flag_q(flag_q6), .busy(busy6),
        .sweep_done(sweep_done6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_sidx  = 0;
        m_ptr   = 0;
        m_flags = '0;
        m_s     = '0;
        m_r     = '0;
    endtask

    // One clock: check the grant before the edge, advance the model, check outputs after.
    task automatic step();
        logic [3:0] eg;
        logic [7:0] ns, nr;
        logic [2:0] idx;
        int         k;
        #1;
        eg = '0;
        k  = -1;
        if (m_mode == 0 && !clr_all) begin
            for (int o = 0; o < 4; o++) begin
                if (k < 0 && req_valid[(m_ptr + o) % 4]) k = (m_ptr + o) % 4;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(eg));

        ns = '0;
        nr = '0;
        m_flags = (m_flags | m_s) & ~m_r;
        case (m_mode)
            0: begin
                if (clr_all) begin
                    m_mode = 1;
                    m_sidx = 0;
                end else if (k >= 0) begin
                    m_ptr = (k + 1) % 4;
                    idx   = req_idx[k*3 +: 3];
                    if (req_op[k]) ns[idx] = 1'b1;
                    else           nr[idx] = 1'b1;
                end
            end
            1: begin
                nr[m_sidx] = 1'b1;
                if (m_sidx == 7) m_mode = 2;
                else             m_sidx++;
            end
            default: m_mode = 0;
        endcase
        m_s = ns;
        m_r = nr;

        @(posedge clk);
        #1;
        chk("s_vec", 32'(s_vec), 32'(m_s));
        chk("r_vec", 32'(r_vec), 32'(m_r));
        chk("flag_q", 32'(flag_q), 32'(m_flags));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("sweep_done", 32'(sweep_done), 32'(m_mode == 2));
        chk("inv_overlap", 32'(s_vec & r_vec), 32'(0));
        chk("inv_onehot", 32'($countones(s_vec | r_vec) <= 1), 32'(1));
        if (sweep_done) done_cnt++;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_op    = '0;
        req_idx   = '0;
        clr_all   = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks its immediate effect, releases after one edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk({tag, "_flag"}, 32'(flag_q), 32'(0));
        chk({tag, "_s"}, 32'(s_vec), 32'(0));
        chk({tag, "_r"}, 32'(r_vec), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        req_valid6 = '0; req_op6 = '0; req_idx6 = '0; clr_all6 = 1'b0;
        model_reset();
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flag", 32'(flag_q), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(sweep_done), 32'(0));
        rst = 1'b1;

        // Preload some flags, then reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001; req_op = 4'b0001; req_idx = 12'(i * 2);
            step();
        end
        idle_inputs();
        step();
        chk("preload", 32'(flag_q), 32'h15);
        async_reset("rst1");
        step();

        // Reset in the middle of a sweep aborts it.
        clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        repeat (3) step();
        async_reset("rst2");
        step();
        step();

        // Requester 1 set then clear index 3.
        req_valid = 4'b0010; req_op = 4'b0010; req_idx = 12'h018;
        #1;
        chk("t2_ready", 32'(req_ready), 32'h2);
        step();
        chk("t2_s", 32'(s_vec), 32'h08);
        idle_inputs();
        step();
        chk("t2_flag_set", 32'(flag_q), 32'h08);
        req_valid = 4'b0010; req_op = 4'b0000; req_idx = 12'h018;
        step();
        chk("t2_r", 32'(r_vec), 32'h08);
        idle_inputs();
        step();
        chk("t2_flag_clr", 32'(flag_q), 32'h00);

        // All four requesters set their own index from pointer 0.
        async_reset("rst3");
        req_valid = 4'hF; req_op = 4'hF; req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        repeat (5) step();
        chk("t3_flag", 32'(flag_q), 32'h0F);

        // Bring pointer to 2, then requesters 0 (set 5) and 2 (clear 5) contend.
        req_valid = 4'b0010; req_op = 4'b0010; req_idx = {3'd0, 3'd0, 3'd1, 3'd0};
        step();
        req_valid = 4'b0101; req_op = 4'b0001; req_idx = {3'd0, 3'd5, 3'd0, 3'd5};
        #1;
        chk("t4_ready_first", 32'(req_ready), 32'h4);
        step();
        chk("t4_r", 32'(r_vec), 32'h20);
        #1;
        chk("t4_ready_second", 32'(req_ready), 32'h1);
        step();
        chk("t4_s", 32'(s_vec), 32'h20);
        idle_inputs();
        step();
        chk("t4_flag5", 32'(flag_q[5]), 32'(1));

        // Fill the bank, then sweep with all requesters pending.
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b0001; req_op = 4'b0001; req_idx = 12'(i);
            step();
        end
        idle_inputs();
        step();
        chk("t5_full", 32'(flag_q), 32'hFF);
        done_cnt = 0;
        req_valid = 4'hF; req_op = 4'hF; clr_all = 1'b1;
        step();
        clr_all = 1'b0;
        for (int i = 0; i < 9; i++) begin
            clr_all = (i == 3);
            step();
            if (i < 8) chk("t5_walk", 32'(r_vec), 32'(8'h01 << i));
        end
        idle_inputs();
        repeat (2) step();
        chk("t5_flag", 32'(flag_q), 32'h00);
        chk("t5_done_cnt", 32'(done_cnt), 32'(1));

        // Out-of-range index on the six-flag instance.
        req_valid6 = 4'b0001; req_op6 = 4'b0001; req_idx6 = 12'h007;
        #1;
        chk("t6_ready", 32'(req_ready6), 32'h1);
        step();
        chk("t6_s", 32'(s_vec6), 32'h0);
        chk("t6_r", 32'(r_vec6), 32'h0);
        req_valid6 = 4'b0011; req_op6 = 4'b0011; req_idx6 = {3'd0, 3'd0, 3'd3, 3'd2};
        #1;
        chk("t6_ptr_adv", 32'(req_ready6), 32'h2);
        step();
        chk("t6_s_valid", 32'(s_vec6), 32'h08);
        chk("t6_flag", 32'(flag_q6), 32'h00);
        req_valid6 = '0;

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_op    = 4'($urandom_range(0, 15));
            req_idx   = 12'($urandom);
            clr_all   = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
